// File: rtl/vliw_pkg.sv
// Shared constants and helpers for the VLIW dispatch block.
package vliw_pkg;

    localparam int unsigned DEF_CORES    = 4;
    localparam int unsigned DEF_INST_LEN = 32;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    // Upper bounds for the slot-slice helper; the top zero-extends its bundle
    // to MAX_BUNDLE_W so a single function signature serves every instance.
    localparam int unsigned MAX_INST_W   = 64;
    localparam int unsigned MAX_BUNDLE_W = 1024;

    // Returns slot idx of a bundle (slot 0 in the LSBs), right-aligned and
    // masked to inst_len bits.
    function automatic logic [MAX_INST_W-1:0] slot_of(
        input logic [MAX_BUNDLE_W-1:0] bundle,
        input int unsigned             inst_len,
        input int unsigned             idx
    );
        logic [MAX_INST_W-1:0] mask;
        if (inst_len >= MAX_INST_W) begin
            mask = '1;
        end else begin
            mask = (MAX_INST_W'(1) << inst_len) - MAX_INST_W'(1);
        end
        return MAX_INST_W'(bundle >> (inst_len * idx)) & mask;
    endfunction

endpackage

// File: rtl/vliw_slot.sv
// One dispatch slot: the registered instruction and its pending flag.
module vliw_slot
    import vliw_pkg::*;
#(
    parameter int unsigned INST_LEN = DEF_INST_LEN
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                load_i,
    input  logic [INST_LEN-1:0] load_data_i,
    input  logic                load_pending_i,
    input  logic                retire_i,
    input  logic                flush_i,
    output logic [INST_LEN-1:0] inst_o,
    output logic                pending_o
);

    logic [INST_LEN-1:0] inst_q, inst_d;
    logic                pending_q, pending_d;

    // Next state: a load wins over retire/flush so back-to-back bundles
    // issue without a bubble; the instruction only changes on load.
    always_comb begin
        inst_d    = inst_q;
        pending_d = pending_q;
        if (load_i) begin
            inst_d    = load_data_i;
            pending_d = load_pending_i;
        end else if (flush_i || retire_i) begin
            pending_d = 1'b0;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            inst_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            inst_q    <= inst_d;
            pending_q <= pending_d;
        end
    end

    assign inst_o    = inst_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/vliw_dispatch.sv
// VLIW bundle splitter: accepts a bundle when every slot of the previous one
// has retired, presents each slot to its core with its own handshake, and
// keeps saturating bundle/stall counters.
module vliw_dispatch
    import vliw_pkg::*;
#(
    parameter int unsigned         CORES    = DEF_CORES,
    parameter int unsigned         INST_LEN = DEF_INST_LEN,
    parameter logic [INST_LEN-1:0] NOP_INST = INST_LEN'(DEF_NOP_INST),
    parameter bit                  SKIP_NOP = 1'b1,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               vliw_valid,
    output logic                               vliw_ready,
    input  logic [INST_LEN*CORES-1:0]          vliw,
    output logic [CORES-1:0][INST_LEN-1:0]     instructions,
    output logic [CORES-1:0]                   inst_valid,
    input  logic [CORES-1:0]                   core_ready,
    output logic                               busy,
    output logic [CNT_W-1:0]                   bundle_cnt,
    output logic [CNT_W-1:0]                   stall_cnt
);

    logic [MAX_BUNDLE_W-1:0] vliw_ext;
    logic [CORES-1:0]        pending;
    logic                    last_retire;
    logic                    accept;
    logic                    stall;
    logic [CNT_W-1:0]        bundle_cnt_q, bundle_cnt_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

    assign vliw_ext = MAX_BUNDLE_W'(vliw);

    for (genvar i = 0; i < CORES; i++) begin : g_slot
        logic [INST_LEN-1:0] slot_data;
        logic                slot_live;

        assign slot_data = INST_LEN'(slot_of(vliw_ext, INST_LEN, i));
        // NOP slots retire on capture when skipping is enabled.
        assign slot_live = !(SKIP_NOP && (slot_data == NOP_INST));

        vliw_slot #(
            .INST_LEN (INST_LEN)
        ) u_slot (
            .clk_i          (clk),
            .rst_n_i        (rst_n),
            .load_i         (accept),
            .load_data_i    (slot_data),
            .load_pending_i (slot_live),
            .retire_i       (pending[i] && core_ready[i]),
            .flush_i        (flush),
            .inst_o         (instructions[i]),
            .pending_o      (pending[i])
        );
    end

    assign inst_valid  = pending;
    assign busy        = |pending;
    assign last_retire = ((pending & ~core_ready) == '0);
    assign vliw_ready  = rst_n && !flush && last_retire;
    assign accept      = vliw_valid && vliw_ready;
    assign stall       = busy && !last_retire;

    // Saturating counter updates.
    always_comb begin
        bundle_cnt_d = bundle_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (accept && !(&bundle_cnt_q)) begin
            bundle_cnt_d = bundle_cnt_q + CNT_W'(1);
        end
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bundle_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bundle_cnt_q <= bundle_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bundle_cnt = bundle_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_vliw_dispatch.sv
// Scoreboard bench for vliw_dispatch: per-core queues of outstanding
// instructions form the reference; the monitor compares at negedge.
module tb_vliw_dispatch;

    localparam int CORES = 4;
    localparam int IL    = 32;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        flush = 1'b0;
    logic                        vliw_valid = 1'b0;
    logic                        vliw_ready;
    logic [IL*CORES-1:0]         vliw = '0;
    logic [CORES-1:0][IL-1:0]    instructions;
    logic [CORES-1:0]            inst_valid;
    logic [CORES-1:0]            core_ready = '0;
    logic                        busy;
    logic [15:0]                 bundle_cnt;
    logic [15:0]                 stall_cnt;

    vliw_dispatch #(
        .CORES    (CORES),
        .INST_LEN (IL),
        .NOP_INST (32'h0),
        .SKIP_NOP (1'b1),
        .CNT_W    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .vliw_valid   (vliw_valid),
        .vliw_ready   (vliw_ready),
        .vliw         (vliw),
        .instructions (instructions),
        .inst_valid   (inst_valid),
        .core_ready   (core_ready),
        .busy         (busy),
        .bundle_cnt   (bundle_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: instructions still owed to each core, last value
    // loaded into each slot, and unsaturated event counts.
    logic [IL-1:0] exp_q [CORES][$];
    logic [IL-1:0] exp_inst [CORES];
    longint        n_bundles = 0;
    longint        n_stalls  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input longint v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    // Monitor: compare outputs against the reference, then advance it to
    // what the coming posedge should produce.
    initial begin
        logic            all_ok;
        logic            any_pend;
        logic [CORES-1:0] exp_mask;
        logic            exp_ready;
        logic [IL-1:0]   popped;
        logic [IL-1:0]   slot;
        for (int i = 0; i < CORES; i++) exp_inst[i] = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            all_ok   = 1'b1;
            any_pend = 1'b0;
            exp_mask = '0;
            for (int i = 0; i < CORES; i++) begin
                if (exp_q[i].size() != 0) begin
                    any_pend    = 1'b1;
                    exp_mask[i] = 1'b1;
                    if (!core_ready[i]) all_ok = 1'b0;
                end
            end
            exp_ready = rst_n && !flush && all_ok;
            chk("vliw_ready", 64'(vliw_ready), 64'(exp_ready));
            chk("inst_valid", 64'(inst_valid), 64'(exp_mask));
            chk("busy", 64'(busy), 64'(any_pend));
            chk("bundle_cnt", 64'(bundle_cnt), 64'(sat16(n_bundles)));
            chk("stall_cnt", 64'(stall_cnt), 64'(sat16(n_stalls)));
            for (int i = 0; i < CORES; i++)
                chk($sformatf("instructions%0d", i), 64'(instructions[i]), 64'(exp_inst[i]));

            if (!rst_n) begin
                for (int i = 0; i < CORES; i++) begin
                    exp_q[i].delete();
                    exp_inst[i] = '0;
                end
                n_bundles = 0;
                n_stalls  = 0;
            end else begin
                if (any_pend && !all_ok) n_stalls++;
                for (int i = 0; i < CORES; i++) begin
                    if (exp_mask[i] && core_ready[i]) begin
                        popped = exp_q[i].pop_front();
                        chk($sformatf("retire_inst%0d", i), 64'(instructions[i]), 64'(popped));
                    end
                end
                if (flush) for (int i = 0; i < CORES; i++) exp_q[i].delete();
                if (vliw_valid && exp_ready) begin
                    n_bundles++;
                    for (int i = 0; i < CORES; i++) begin
                        slot = vliw[i*IL +: IL];
                        exp_inst[i] = slot;
                        if (slot != '0) exp_q[i].push_back(slot);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IL-1:0] rnd_slot();
        return ($urandom_range(3) == 0) ? '0 : IL'($urandom);
    endfunction

    // Stimulus.
    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic bundle with every core ready.
        vliw = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        core_ready = 4'hF;
        vliw_valid = 1'b1;
        tick();
        vliw_valid = 1'b0;
        repeat (3) tick();

        // Staggered retire.
        core_ready = 4'h0;
        vliw = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
        vliw_valid = 1'b1;
        tick();
        vliw_valid = 1'b0;
        core_ready = 4'h1; tick();
        core_ready = 4'h2; tick();
        core_ready = 4'h4; tick();
        core_ready = 4'h8; tick();
        core_ready = 4'h0; tick();

        // NOP skipping, then an all-NOP bundle.
        vliw = {32'h0, 32'hCCCC0003, 32'h0, 32'hAAAA0001};
        vliw_valid = 1'b1;
        tick();
        vliw_valid = 1'b0;
        repeat (2) tick();
        core_ready = 4'hF; tick();
        vliw = '0;
        vliw_valid = 1'b1;
        tick();
        vliw_valid = 1'b0;
        repeat (2) tick();

        // Back-to-back bundles.
        vliw_valid = 1'b1;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < CORES; i++) vliw[i*IL +: IL] = IL'(32'h1000_0000 * (b + 1) + i + 1);
            tick();
        end
        vliw_valid = 1'b0;
        repeat (2) tick();

        // Flush with slots 1 and 3 pending and upstream valid.
        core_ready = 4'h0;
        vliw = {32'hDDDD0004, 32'h0, 32'hBBBB0002, 32'h0};
        vliw_valid = 1'b1;
        tick();
        vliw = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vliw_valid = 1'b0;
        repeat (2) tick();
        flush = 1'b1; tick();
        flush = 1'b0; tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            vliw_valid = ($urandom_range(3) != 0);
            core_ready = 4'($urandom);
            flush      = ($urandom_range(31) == 0);
            for (int i = 0; i < CORES; i++) vliw[i*IL +: IL] = rnd_slot();
            tick();
        end
        flush = 1'b0;
        vliw_valid = 1'b0;

        // Reset mid-bundle.
        core_ready = 4'h0;
        vliw = {32'h1, 32'h2, 32'h3, 32'h4};
        vliw_valid = 1'b1;
        tick();
        vliw_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Stall-counter saturation.
        vliw = {32'h5, 32'h6, 32'h7, 32'h8};
        vliw_valid = 1'b1;
        tick();
        vliw_valid = 1'b0;
        repeat (65540) tick();
        core_ready = 4'hF;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
